// File: rtl/ttoggle_sequencer_pkg.sv
// rtl/ttoggle_sequencer_pkg.sv - shared state encoding and default widths
package ttoggle_sequencer_pkg;

  localparam int DEF_W_CNT = 8;
  localparam int DEF_W_PER = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/ttoggle_sequencer_if.sv
// rtl/ttoggle_sequencer_if.sv - host command / trigger status bundle
interface ttoggle_sequencer_if #(
  parameter int W_CNT = ttoggle_sequencer_pkg::DEF_W_CNT,
  parameter int W_PER = ttoggle_sequencer_pkg::DEF_W_PER
);
  logic             start;
  logic [W_CNT-1:0] count;
  logic [W_PER-1:0] period;
  logic             abort;
  logic             T;
  logic             Q;
  logic             nQ;
  logic             busy;
  logic             done;
  logic [W_CNT-1:0] remaining;

  modport master (
    output start, count, period, abort,
    input  T, Q, nQ, busy, done, remaining
  );

  modport slave (
    input  start, count, period, abort,
    output T, Q, nQ, busy, done, remaining
  );
endinterface

// File: rtl/ttoggle_sequencer_period_timer.sv
// rtl/ttoggle_sequencer_period_timer.sv - loadable down-counter with zero flag
module ttoggle_sequencer_period_timer #(
  parameter int W = ttoggle_sequencer_pkg::DEF_W_PER
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;

  // load beats decrement so a strobe cycle can rearm the spacing
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && !o_zero) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/ttoggle_sequencer.sv
// rtl/ttoggle_sequencer.sv - burst sequencer driving a T trigger, with Q/nQ state
module ttoggle_sequencer #(
  parameter int W_CNT = ttoggle_sequencer_pkg::DEF_W_CNT,
  parameter int W_PER = ttoggle_sequencer_pkg::DEF_W_PER
) (
  input logic               clk,
  input logic               rst,
  ttoggle_sequencer_if.slave bus
);
  import ttoggle_sequencer_pkg::*;

  state_e           r_state;
  state_e           w_next_state;
  logic             r_q;
  logic             r_done;
  logic [W_CNT-1:0] r_remaining;
  logic [W_PER-1:0] r_per;

  logic             w_t;
  logic             w_accept;
  logic             w_zero_cmd;
  logic             w_last;
  logic             w_abort_run;
  logic             w_load;
  logic [W_PER-1:0] w_load_val;
  logic             w_tmr_en;
  logic             w_tmr_zero;

  ttoggle_sequencer_period_timer #(.W(W_PER)) u_period_timer (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (w_tmr_en),
    .o_zero     (w_tmr_zero)
  );

  always_comb begin
    w_next_state = r_state;
    w_t          = 1'b0;
    w_accept     = 1'b0;
    w_zero_cmd   = 1'b0;
    w_last       = 1'b0;
    w_abort_run  = 1'b0;
    w_load       = 1'b0;
    w_load_val   = r_per;
    w_tmr_en     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // abort in the same cycle drops the command entirely
        if (bus.start && !bus.abort) begin
          if (bus.count != '0) begin
            w_accept     = 1'b1;
            w_load       = 1'b1;
            w_load_val   = bus.period;
            w_next_state = ST_RUN;
          end else begin
            w_zero_cmd = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          w_abort_run  = 1'b1;
          w_next_state = ST_IDLE;
        end else if (w_tmr_zero) begin
          w_t    = 1'b1;
          w_load = 1'b1;
          if (r_remaining == W_CNT'(1)) begin
            w_last       = 1'b1;
            w_next_state = ST_IDLE;
          end
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_q         <= 1'b0;
      r_done      <= 1'b0;
      r_remaining <= '0;
      r_per       <= '0;
    end else begin
      r_state <= w_next_state;
      r_done  <= w_last || w_zero_cmd;
      if (w_accept) begin
        r_remaining <= bus.count;
        r_per       <= bus.period;
      end else if (w_abort_run) begin
        r_remaining <= '0;
      end else if (w_t) begin
        r_remaining <= r_remaining - 1'b1;
      end
      if (w_t) begin
        r_q <= ~r_q;
      end
    end
  end

  assign bus.T         = w_t;
  assign bus.Q         = r_q;
  assign bus.nQ        = ~r_q;
  assign bus.busy      = (r_state == ST_RUN);
  assign bus.done      = r_done;
  assign bus.remaining = r_remaining;
endmodule

// File: tb/tb_ttoggle_sequencer.sv
// tb/tb_ttoggle_sequencer.sv - self-checking bench for ttoggle_sequencer
module tb_ttoggle_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ttoggle_sequencer_if #(.W_CNT(8), .W_PER(8)) bus ();

  ttoggle_sequencer #(.W_CNT(8), .W_PER(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t_log[$];
  int done_log[$];

  // reference: strobe times follow from the accept cycle by arithmetic
  int m_active = 0;
  int m_acc    = 0;
  int m_per    = 0;
  int m_rem    = 0;
  int m_q      = 0;
  int m_done   = 0;
  int e_t;
  int nd;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d expected %0d", name, cyc, got, exp);
    end
  endtask

  task automatic chk_q(input string name, input int got[$], input int exp[$]);
    logic ok;
    ok = (got.size() == exp.size());
    if (ok) begin
      for (int i = 0; i < got.size(); i++) begin
        if (got[i] != exp[i]) ok = 1'b0;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got %0d entries (first %0d) expected %0d entries (first %0d)", name,
               got.size(), (got.size() > 0) ? got[0] : -1,
               exp.size(), (exp.size() > 0) ? exp[0] : -1);
    end
  endtask

  always @(negedge clk) begin
    e_t = (m_active != 0 && !bus.abort && cyc >= m_acc + 1 + m_per &&
           ((cyc - m_acc - 1 - m_per) % (m_per + 1)) == 0) ? 1 : 0;
    if (cyc >= 1) begin
      chk("T", {31'd0, bus.T}, e_t);
      chk("Q", {31'd0, bus.Q}, m_q);
      chk("nQ", {31'd0, bus.nQ}, 1 - m_q);
      chk("busy", {31'd0, bus.busy}, m_active);
      chk("done", {31'd0, bus.done}, m_done);
      chk("remaining", {24'd0, bus.remaining}, m_rem);
    end
    if (bus.T) t_log.push_back(cyc);
    if (bus.done) done_log.push_back(cyc);
    if (rst) begin
      m_active = 0; m_q = 0; m_rem = 0; m_done = 0; m_per = 0;
    end else begin
      nd = 0;
      if (m_active != 0) begin
        if (bus.abort) begin
          m_active = 0;
          m_rem    = 0;
        end else if (e_t != 0) begin
          m_q   = 1 - m_q;
          m_rem = m_rem - 1;
          if (m_rem == 0) begin
            m_active = 0;
            nd       = 1;
          end
        end
      end else if (bus.start && !bus.abort) begin
        if (bus.count == 0) begin
          nd = 1;
        end else begin
          m_active = 1;
          m_acc    = cyc;
          m_per    = int'(bus.period);
          m_rem    = int'(bus.count);
        end
      end
      m_done = nd;
    end
    cyc++;
  end

  task automatic drive(input logic st, input int cnt, input int per, input logic ab, input logic r);
    @(posedge clk);
    #1;
    bus.start  = st;
    bus.count  = 8'(cnt);
    bus.period = 8'(per);
    bus.abort  = ab;
    rst        = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    drive(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  int s;
  int e[$];

  initial begin
    bus.start  = 1'b0;
    bus.count  = '0;
    bus.period = '0;
    bus.abort  = 1'b0;
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    chk("reset_Q", {31'd0, bus.Q}, 0);
    chk("reset_nQ", {31'd0, bus.nQ}, 1);
    chk("reset_busy", {31'd0, bus.busy}, 0);
    chk("reset_done", {31'd0, bus.done}, 0);
    chk("reset_rem", {24'd0, bus.remaining}, 0);

    // basic burst: count 3, period 2
    drive(1'b1, 3, 2, 1'b0, 1'b0); s = cyc; t_log.delete(); done_log.delete();
    idle(13);
    e = '{s + 3, s + 6, s + 9}; chk_q("basic_T", t_log, e);
    e = '{s + 10};              chk_q("basic_done", done_log, e);
    chk("basic_Q", {31'd0, bus.Q}, 1);

    // period 0: back-to-back strobes
    do_reset();
    drive(1'b1, 4, 0, 1'b0, 1'b0); s = cyc; t_log.delete(); done_log.delete();
    idle(8);
    e = '{s + 1, s + 2, s + 3, s + 4}; chk_q("p0_T", t_log, e);
    e = '{s + 5};                      chk_q("p0_done", done_log, e);
    chk("p0_Q", {31'd0, bus.Q}, 0);

    // zero count
    do_reset();
    drive(1'b1, 0, 5, 1'b0, 1'b0); s = cyc; t_log.delete(); done_log.delete();
    idle(4);
    e.delete();  chk_q("c0_T", t_log, e);
    e = '{s + 1}; chk_q("c0_done", done_log, e);

    // abort after the second strobe
    do_reset();
    drive(1'b1, 5, 3, 1'b0, 1'b0); s = cyc; t_log.delete(); done_log.delete();
    idle(8);
    drive(1'b0, 0, 0, 1'b1, 1'b0);
    idle(1);
    chk("abort_busy", {31'd0, bus.busy}, 0);
    chk("abort_rem", {24'd0, bus.remaining}, 0);
    chk("abort_Q", {31'd0, bus.Q}, 0);
    idle(25);
    e = '{s + 4, s + 8}; chk_q("abort_T", t_log, e);
    e.delete();          chk_q("abort_done", done_log, e);

    // start while busy ignored; start in done cycle accepted
    do_reset();
    drive(1'b1, 2, 1, 1'b0, 1'b0); s = cyc; t_log.delete(); done_log.delete();
    idle(1);
    drive(1'b1, 7, 0, 1'b0, 1'b0);
    idle(2);
    drive(1'b1, 1, 0, 1'b0, 1'b0);
    idle(1);
    chk("b2b_busy", {31'd0, bus.busy}, 1);
    idle(4);
    e = '{s + 2, s + 4, s + 6}; chk_q("b2b_T", t_log, e);
    e = '{s + 5, s + 7};        chk_q("b2b_done", done_log, e);

    // reset mid-burst
    do_reset();
    drive(1'b1, 3, 2, 1'b0, 1'b0); s = cyc; t_log.delete(); done_log.delete();
    idle(3);
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    idle(1);
    chk("rstmid_Q", {31'd0, bus.Q}, 0);
    chk("rstmid_nQ", {31'd0, bus.nQ}, 1);
    chk("rstmid_busy", {31'd0, bus.busy}, 0);
    chk("rstmid_rem", {24'd0, bus.remaining}, 0);
    chk("rstmid_done", {31'd0, bus.done}, 0);
    idle(3);
    e = '{s + 3}; chk_q("rstmid_T", t_log, e);
    e.delete();   chk_q("rstmid_done_log", done_log, e);

    // randomized traffic against the reference
    for (int i = 0; i < 4000; i++) begin
      drive(($urandom_range(0, 3) == 0),
            ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 5)),
            ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 4)),
            ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 299) == 0));
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ttoggle_sequencer.md
# ttoggle_sequencer

Programmable sequencer for a synchronous T trigger. On command it issues a burst of `count` toggle strobes, evenly spaced by a programmable period. It also maintains the resulting trigger state (`Q`/`nQ`) internally, with a defined reset value. It sits between a host/control FSM and any logic that needs a clock-divided or pulse-counted toggling signal, and reports busy/done to the host.

## Interface
- `W_CNT`, default 8: width of toggle count.
- `W_PER`, default 8: width of period field.

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  command strobe, sampled on rising `clk`.
- `count`  in  W_CNT  number of toggles, latched with `start`.
- `period`  in  W_PER  idle cycles between toggles, latched with `start`.
- `abort`  in  1  stop the burst immediately.
- `T`  out  1  one-cycle toggle strobe (the trigger's T input).
- `Q`  out  1  trigger state.
- `nQ`  out  1  always `~Q`.
- `busy`  out  1  burst in progress.
- `done`  out  1  one-cycle pulse on normal completion.
- `remaining`  out  W_CNT  toggles still to issue.

## Operation
- FSM states: `IDLE`, `RUN`.
- **`IDLE`:**
  - `start=1` with `count!=0` (and `abort=0`) latches `count` into `remaining` and `period` into the timer, then moves to `RUN`.
  - `start=1` with `count==0` produces `done=1` for one cycle next cycle and stays in `IDLE`. No toggle is issued.
- **`RUN`:**
  - The timer decrements each cycle while nonzero.
  - In the cycle the timer equals 0:
    - `T=1`;
    - `Q` toggles at the end of that cycle;
    - `remaining` decrements;
    - the timer reloads from the latched period.
  - If `remaining` reaches 0, go to `IDLE` and assert `done` for the following cycle.
- `period` is treated as unsigned. `period=0` gives `T` on every cycle of the burst. Spacing between strobes is `period+1` cycles.
- `start` while `busy=1` is ignored; the latched parameters stay unchanged.
- **`abort`:**
  - In `RUN`, `abort` returns to `IDLE` next cycle and clears `remaining` to 0. No `done` and no `T` are issued in the abort cycle; `Q` holds its current value.
  - In `IDLE`, `abort` and `start` in the same cycle: `abort` wins and `start` is dropped.
- `Q` changes only on a `T` strobe or on reset. `nQ=~Q` always.

## Timing
- Reset values: state `IDLE`, `T=0`, `Q=0`, `nQ=1`, `busy=0`, `done=0`, `remaining=0`, timer 0.
- `rst` takes priority over all inputs and acts mid-burst: it returns to the reset values on the next edge, with no `done`.
- Latency, with `start` sampled at edge k:
  - `busy=1` from cycle k+1;
  - first `T` in cycle k+1+`period`;
  - the n-th `T` in cycle k+1+`period`+(n−1)(`period`+1).
- `Q` reflects each toggle from the cycle after its `T`.
- `done` is asserted in the cycle after the last `T`. `busy` is 0 in that same cycle, so a new `start` is accepted in the `done` cycle.
- `remaining` is registered. It shows the value after decrement from the cycle after each `T`.
- `count==0` case: `done` in cycle k+1; `busy` stays 0.

## Structure
- Shared package holds:
  - the state encoding (`IDLE`/`RUN`, 1-bit);
  - default `W_CNT`/`W_PER` constants.
- One sub-module, `period_timer`: loadable down-counter with `load`, `load_val`, `en`, and a `zero` flag.
- The FSM, toggle register and `remaining` counter live in the top.

## Test plan
- Reset and basic burst:
  - Stimulus: reset, then `count=3`, `period=2`, `start` at cycle 0.
  - Required: `T` in cycles 3, 6, 9. `Q`=1 from 4, 0 from 7, 1 from 10. `done` in cycle 10. `busy` in cycles 1–9. `remaining` 3→2→1→0.
- `period=0`, `count=4`:
  - Required: `T` in 4 consecutive cycles 1–4; `Q` ends at 0; `done` in cycle 5.
- `count=0`:
  - Required: no `T`; `done` in cycle 1; `busy` never 1.
- `abort`:
  - Stimulus: `count=5`, `period=3`, with `abort` in the cycle after the second `T`.
  - Required: no further `T`; `Q` holds 0; `busy` drops next cycle; no `done`; `remaining=0`.
- `start` while busy, plus back-to-back:
  - Stimulus: second `start` mid-burst with `count=7`.
  - Required: it is ignored and the original burst completes.
  - Stimulus: `start` in the `done` cycle.
  - Required: accepted; `busy` in the next cycle.
- Reset mid-burst:
  - Stimulus: `rst` in the cycle after the first `T`.
  - Required: next cycle shows `Q=0`, `nQ=1`, `busy=0`, `remaining=0`, and no `done`.
